serial_subtract_ctrl: RTL and testbench

Bit-serial multi-bit subtractor controller that computes A − B over WIDTH cycles, one bit per cycle, LSB first. It reuses a single-bit difference/borrow datapath: two half-subtractor stages plus a registered borrow. It is the sequencing layer that lets the team's 1-bit subtractor logic handle WIDTH-bit operands, with a start/busy/done handshake toward the requesting logic.

---
 rtl/serial_subtract_ctrl.sv | 111 +++++++++++
 tb/tb_serial_subtract_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtract_ctrl.sv
// Bit-serial WIDTH-bit subtractor: computes a - b one bit per cycle, LSB first,
// using two half-subtractor stages and a registered borrow, with start/busy/done handshake.
module serial_subtract_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic [1:0]       dbg_state
);

    // Handshake: start is honoured only in IDLE (busy=0); the accepting edge captures
    // a and b. busy stays high from that edge through the one-cycle done pulse.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic             r_br;

    logic             w_d1;
    logic             w_b1;
    logic             w_dbit;
    logic             w_b2;
    logic             w_br_next;
    logic [WIDTH:0]   w_sr_cat;
    logic [WIDTH-1:0] w_sr_next;

    assign w_d1      = r_sa[0] ^ r_sb[0];
    assign w_b1      = ~r_sa[0] & r_sb[0];
    assign w_dbit    = w_d1 ^ r_br;
    assign w_b2      = ~w_d1 & r_br;
    assign w_br_next = w_b1 | w_b2;

    // Concatenate-then-slice keeps the shift legal when WIDTH is 1.
    assign w_sr_cat  = {w_dbit, r_sr};
    assign w_sr_next = w_sr_cat[WIDTH:1];

    assign dbg_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_br    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            borrow  <= 1'b0;
            zero    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_br  <= w_br_next;
                    r_sr  <= w_sr_next;
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        diff    <= w_sr_next;
                        borrow  <= w_br_next;
                        zero    <= (w_sr_next == '0);
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// Self-checking bench for serial_subtract_ctrl: WIDTH=8 and WIDTH=1 instances with
// scoreboard queues filled at stimulus time and drained on each done pulse.
module tb_serial_subtract_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, borrow8, zero8;
    logic [7:0] diff8;
    logic [1:0] st8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, borrow1, zero1;
    logic [0:0] diff1;
    logic [1:0] st1;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt8 = 0;
    int done_cnt1 = 0;
    int exp_done8 = 0;
    int exp_done1 = 0;

    logic [9:0] exp_q[$];
    logic [2:0] exp1_q[$];

    serial_subtract_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .zero(zero8),
        .dbg_state(st8)
    );

    serial_subtract_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1), .zero(zero1),
        .dbg_state(st1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: {diff, borrow, zero} from a 9-bit unsigned subtraction.
    function automatic logic [9:0] model8(input logic [7:0] av, input logic [7:0] bv);
        logic [8:0] d;
        d = {1'b0, av} - {1'b0, bv};
        return {d[7:0], d[8], d[7:0] == 8'h00};
    endfunction

    always @(negedge clk) begin
        if (!rst && done8) begin
            logic [9:0] e;
            done_cnt8++;
            if (exp_q.size() == 0) begin
                check("spurious_done8", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("diff8", diff8, e[9:2]);
                check("borrow8", borrow8, e[1]);
                check("zero8", zero8, e[0]);
            end
        end
        if (!rst && done1) begin
            logic [2:0] e1;
            done_cnt1++;
            if (exp1_q.size() == 0) begin
                check("spurious_done1", 1, 0);
            end else begin
                e1 = exp1_q.pop_front();
                check("diff1", diff1, e1[2]);
                check("borrow1", borrow1, e1[1]);
                check("zero1", zero1, e1[0]);
            end
        end
    end

    // One WIDTH=8 operation; optionally pulses a competing start during RUN.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input bit inject);
        int n;
        logic [7:0] held;
        @(negedge clk);
        check("idle_before_op8", busy8, 0);
        a8 = av; b8 = bv; start8 = 1'b1;
        exp_q.push_back(model8(av, bv));
        exp_done8++;
        held = diff8;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom_range(0, 255));
        b8 = 8'($urandom_range(0, 255));
        n = 1;
        while (!done8 && n < 40) begin
            check("busy_run8", busy8, 1);
            check("diff_hold8", diff8, held);
            if (inject && n == 3) begin
                start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start8 = 1'b0;
        check("latency8", n, 9);
        check("busy_done8", busy8, 1);
        @(negedge clk);
        check("busy_idle8", busy8, 0);
    endtask

    task automatic op1(input logic av, input logic bv, input logic [2:0] e);
        int n;
        @(negedge clk);
        a1 = av; b1 = bv; start1 = 1'b1;
        exp1_q.push_back(e);
        exp_done1++;
        @(negedge clk);
        start1 = 1'b0;
        n = 1;
        while (!done1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency1", n, 2);
        @(negedge clk);
        check("busy_idle1", busy1, 0);
    endtask

    initial begin
        int k;
        int done_pos[$];
        repeat (3) @(negedge clk);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_diff", diff8, 0);
        check("rst_borrow", borrow8, 0);
        check("rst_zero", zero8, 0);
        check("rst_state", st8, 0);
        rst = 1'b0;

        op8(8'h5A, 8'h3C, 0);
        op8(8'h00, 8'h01, 0);
        op8(8'h80, 8'h80, 0);
        op8(8'h10, 8'h01, 1);
        repeat (15) @(negedge clk);
        check("no_extra_done8", done_cnt8, exp_done8);

        for (int i = 0; i < 4; i++)
            op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0);

        // start held high: accepts every WIDTH+2 cycles.
        @(negedge clk);
        a8 = 8'h03; b8 = 8'h05; start8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(model8(8'h03, 8'h05));
            exp_done8++;
        end
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done8) done_pos.push_back(i);
        end
        start8 = 1'b0;
        check("held_done_count", done_pos.size(), 3);
        if (done_pos.size() == 3) begin
            check("held_done_pos0", done_pos[0], 9);
            check("held_done_pos1", done_pos[1], 19);
            check("held_done_pos2", done_pos[2], 29);
        end
        k = 0;
        while (busy8 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("held_drain_timeout", busy8, 0);

        // Asynchronous abort after four RUN edges.
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_pre", busy8, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy8, 0);
        check("abort_done", done8, 0);
        check("abort_diff", diff8, 0);
        check("abort_borrow", borrow8, 0);
        check("abort_zero", zero8, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_no_done", done_cnt8, exp_done8);
        op8(8'hAA, 8'h55, 0);

        op1(1'b0, 1'b0, 3'b001);
        op1(1'b0, 1'b1, 3'b110);
        op1(1'b1, 1'b0, 3'b100);
        op1(1'b1, 1'b1, 3'b001);

        repeat (5) @(negedge clk);
        check("done_total8", done_cnt8, exp_done8);
        check("done_total1", done_cnt1, exp_done1);
        check("queue_empty8", exp_q.size(), 0);
        check("queue_empty1", exp1_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
